// File: rtl/vx_mem_rsp_credit_buffer.sv
// Credit-controlled response buffer between the Vortex memory port and a memory model.
// Reads issue only when a FIFO slot is reserved, so memory responses are never back-pressured.
module vx_mem_rsp_credit_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    core_req_valid,
  input  logic                    core_req_rw,
  input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_data,
  input  logic [TAG_WIDTH-1:0]    core_req_tag,
  output logic                    core_req_ready,

  output logic                    core_rsp_valid,
  output logic [DATA_WIDTH-1:0]   core_rsp_data,
  output logic [TAG_WIDTH-1:0]    core_rsp_tag,
  input  logic                    core_rsp_ready,

  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [TAG_WIDTH-1:0]    mem_req_tag,
  input  logic                    mem_req_ready,

  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic                    mem_rsp_ready,

  output logic                    busy,
  output logic                    overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // valid never depends on ready of the same channel, and payload is held while valid & !ready.

  logic                  w_can_issue;
  logic                  w_rd_fire;
  logic                  w_rsp_fire;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;

  logic [CNT_W-1:0]      r_credits;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  r_rsp_ready;
  logic                  r_overflow;
  logic [TAG_WIDTH-1:0]  r_tag_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];

  // Writes never need a credit; reads need one free slot in the response FIFO.
  assign w_can_issue    = core_req_rw | (r_credits != DEPTH_C);
  assign mem_req_valid  = core_req_valid & w_can_issue;
  assign core_req_ready = mem_req_ready & w_can_issue;
  assign mem_req_rw     = core_req_rw;
  assign mem_req_byteen = core_req_byteen;
  assign mem_req_addr   = core_req_addr;
  assign mem_req_data   = core_req_data;
  assign mem_req_tag    = core_req_tag;

  assign w_rd_fire  = core_req_valid & core_req_ready & ~core_req_rw;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_rsp_fire = ~w_empty & core_rsp_ready;
  assign w_push     = mem_rsp_valid & r_rsp_ready & ~w_full;

  assign core_rsp_valid = ~w_empty;
  assign core_rsp_data  = r_data_mem[r_rd_ptr];
  assign core_rsp_tag   = r_tag_mem[r_rd_ptr];
  assign mem_rsp_ready  = r_rsp_ready;
  assign busy           = (r_credits != '0);
  assign overflow_err   = r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= '0;
    end else begin
      case ({w_rd_fire, w_rsp_fire})
        2'b10:   if (r_credits != DEPTH_C) r_credits <= r_credits + CNT_ONE;
        2'b01:   if (r_credits != '0)      r_credits <= r_credits - CNT_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rsp_fire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_rsp_fire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A response landing on a full FIFO is dropped; only a misbehaving memory can cause it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_ready <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_rsp_ready <= 1'b1;
      if (mem_rsp_valid & r_rsp_ready & w_full) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the flushed pointers and count make stale entries invisible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr]  <= mem_rsp_tag;
      r_data_mem[r_wr_ptr] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_vx_mem_rsp_credit_buffer.sv
// Bench for vx_mem_rsp_credit_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of credits and buffered responses.
module tb_vx_mem_rsp_credit_buffer;
  localparam int DW    = 512;
  localparam int AW    = 26;
  localparam int TW    = 8;
  localparam int DEPTH = 8;
  localparam int BW    = DW / 8;
  localparam int W     = TW + DW;

  logic          clk;
  logic          reset;
  logic          core_req_valid, core_req_rw, core_req_ready;
  logic [BW-1:0] core_req_byteen;
  logic [AW-1:0] core_req_addr;
  logic [DW-1:0] core_req_data;
  logic [TW-1:0] core_req_tag;
  logic          core_rsp_valid, core_rsp_ready;
  logic [DW-1:0] core_rsp_data;
  logic [TW-1:0] core_rsp_tag;
  logic          mem_req_valid, mem_req_rw, mem_req_ready;
  logic [BW-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          busy, overflow_err;

  vx_mem_rsp_credit_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy), .overflow_err(overflow_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- model / scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];   // responses expected at core_rsp, head first
  logic [TW-1:0] pend_q[$];  // reads the memory model still owes
  int            credits_m = 0;
  bit            ovf_m     = 1'b0;
  bit            rdy_m     = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_outputs();
    bit can;
    check("rsp_valid", core_rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("rsp_tag", core_rsp_tag, exp_q[0][DW +: TW]);
      check("rsp_data", core_rsp_data, exp_q[0][DW-1:0]);
    end
    check("busy", busy, credits_m != 0);
    check("mem_rsp_ready", mem_rsp_ready, rdy_m);
    check("overflow_err", overflow_err, ovf_m);
    can = core_req_rw || (credits_m != DEPTH);
    check("core_req_ready", core_req_ready, mem_req_ready && can);
    check("mem_req_valid", mem_req_valid, core_req_valid && can);
    check("mem_req_fwd", {mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen},
          {core_req_rw, core_req_addr, core_req_tag, core_req_byteen});
    check("mem_req_data", mem_req_data, core_req_data);
  endtask

  // Advances the model across the coming rising edge using the current inputs.
  task automatic commit();
    bit rd_fire, rsp_fire, push;
    int occ;
    if (reset) return;
    occ      = exp_q.size();
    rd_fire  = core_req_valid && mem_req_ready && !core_req_rw && (credits_m != DEPTH);
    rsp_fire = (occ != 0) && core_rsp_ready;
    push     = mem_rsp_valid && rdy_m;
    if (rd_fire) begin
      credits_m++;
      pend_q.push_back(core_req_tag);
    end
    if (rsp_fire) begin
      credits_m--;
      void'(exp_q.pop_front());
    end
    if (push) begin
      if (occ == DEPTH) ovf_m = 1'b1;
      else exp_q.push_back({mem_rsp_tag, mem_rsp_data});
      if (pend_q.size() != 0) void'(pend_q.pop_front());
    end
    rdy_m = 1'b1;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    commit();
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input logic v, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
    core_req_valid  = v;
    core_req_rw     = rw;
    core_req_addr   = a;
    core_req_tag    = t;
    core_req_byteen = {$urandom, $urandom};
    core_req_data   = rand_data();
  endtask

  task automatic set_mem_rsp(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    mem_rsp_valid = v;
    mem_rsp_tag   = t;
    mem_rsp_data  = d;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, '0, '0);
    set_mem_rsp(1'b0, '0, '0);
  endtask

  task automatic respond_next();
    set_mem_rsp(pend_q.size() != 0, (pend_q.size() != 0) ? pend_q[0] : '0, rand_data());
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || pend_q.size() != 0); i++) begin
      set_req(1'b0, 1'b0, '0, '0);
      core_rsp_ready = 1'b1;
      respond_next();
      cycle();
    end
    idle();
    #1 check("drain_busy", busy, 1'b0);
  endtask

  task automatic apply_reset();
    idle();
    core_rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_rsp_valid", core_rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
    check("rst_overflow", overflow_err, 1'b0);
    exp_q.delete();
    pend_q.delete();
    credits_m = 0;
    ovf_m     = 1'b0;
    rdy_m     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    #1 check("rst_rel_mem_rsp_ready", mem_rsp_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] hold_data;
  logic [TW-1:0] hold_tag;

  initial begin
    reset = 1'b1;
    mem_req_ready  = 1'b1;
    core_rsp_ready = 1'b0;
    idle();
    @(negedge clk);
    apply_reset();

    // single read, memory answers three cycles after the request
    set_req(1'b1, 1'b0, 26'h100, 8'h05);
    cycle();
    idle();
    cycle();
    cycle();
    set_mem_rsp(1'b1, pend_q[0], {BW{8'hAA}});
    #1 check("t1_no_bypass", core_rsp_valid, 1'b0);
    cycle();
    idle();
    core_rsp_ready = 1'b1;
    #1 check("t1_rsp_valid", core_rsp_valid, 1'b1);
    check("t1_rsp_tag", core_rsp_tag, 8'h05);
    check("t1_rsp_data", core_rsp_data, {BW{8'hAA}});
    cycle();
    #1 check("t1_busy_after_pop", busy, 1'b0);
    cycle();

    // credit exhaustion: eight reads with the core not draining
    core_rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 1'b0, AW'(i * 64), TW'(8'h10 + i));
      cycle();
    end
    set_req(1'b1, 1'b0, 26'h200, 8'h99);
    #1 check("t2_9th_ready", core_req_ready, 1'b0);
    check("t2_9th_valid", mem_req_valid, 1'b0);
    cycle();
    set_req(1'b1, 1'b1, 26'h300, 8'h77);
    #1 check("t2_write_ready", core_req_ready, 1'b1);
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b0, 1'b0, '0, '0);
      respond_next();
      cycle();
    end
    idle();
    core_rsp_ready = 1'b1;
    cycle();
    core_rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 26'h400, 8'h44);
    #1 check("t2_read_reenabled", core_req_ready, 1'b1);
    cycle();
    drain();
    cycle();

    // push and pop in the same cycle at occupancy three
    core_rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, 1'b0, AW'(i), TW'(i));
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 1'b0, '0, '0);
      respond_next();
      cycle();
    end
    set_req(1'b1, 1'b0, 26'h5, 8'h05);
    respond_next();
    core_rsp_ready = 1'b1;
    #1 check("t3_head_1", core_rsp_tag, 8'h01);
    cycle();
    idle();
    for (int i = 2; i <= 4; i++) begin
      #1 check("t3_order", core_rsp_tag, TW'(i));
      cycle();
    end
    drain();
    cycle();

    // head held stable while the core stalls, with a push arriving meanwhile
    core_rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 26'h21, 8'h21);
    cycle();
    set_req(1'b1, 1'b0, 26'h22, 8'h22);
    respond_next();
    cycle();
    idle();
    cycle();
    hold_data = core_rsp_data;
    hold_tag  = core_rsp_tag;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) respond_next();
      else idle();
      #1 check("t4_hold_data", core_rsp_data, hold_data);
      check("t4_hold_tag", core_rsp_tag, hold_tag);
      cycle();
    end
    drain();
    cycle();

    // misbehaving memory delivers a ninth response into a full FIFO
    core_rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 1'b0, AW'(i), TW'(8'h30 + i));
      cycle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b0, 1'b0, '0, '0);
      respond_next();
      cycle();
    end
    set_mem_rsp(1'b1, 8'hEE, rand_data());
    cycle();
    idle();
    #1 check("t5_overflow_set", overflow_err, 1'b1);
    check("t5_head_kept", core_rsp_tag, 8'h30);
    cycle();
    drain();
    #1 check("t5_overflow_sticky", overflow_err, 1'b1);
    cycle();

    // reset with four reads in flight and two responses buffered
    core_rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 1'b0, AW'(i), TW'(8'h50 + i));
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      set_req(1'b0, 1'b0, '0, '0);
      respond_next();
      cycle();
    end
    apply_reset();
    idle();
    #1 check("t6_busy_after_reset", busy, 1'b0);
    cycle();

    // random traffic against an in-order memory model with random latency
    for (int n = 0; n < 3000; n++) begin
      set_req($urandom_range(0, 1), ($urandom_range(0, 3) == 0), AW'($urandom), TW'($urandom));
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      core_rsp_ready = $urandom_range(0, 1);
      if (pend_q.size() != 0 && $urandom_range(0, 2) != 0) respond_next();
      else set_mem_rsp(1'b0, '0, '0);
      cycle();
    end
    mem_req_ready = 1'b1;
    drain();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_mem_rsp_credit_buffer.md
Name: vx_mem_rsp_credit_buffer

Overview:
- Sits between the Vortex memory port and the memory model that serves it.
- Forwards Vortex memory requests downstream and buffers read responses in an in-order FIFO.
- Issues a read only when a FIFO slot is guaranteed for its response (credit scheme), so memory responses are never back-pressured.
- Decouples core response back-pressure from the memory model.

Parameters:
- DATA_WIDTH, 512, memory data width in bits; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 26, memory address width in bits.
- TAG_WIDTH, 8, request/response tag width.
- DEPTH, 8, response FIFO entries and maximum read credits; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- core_req_valid  in  1  request valid from Vortex
- core_req_rw  in  1  1 = write, 0 = read
- core_req_byteen  in  DATA_WIDTH/8  write byte enables
- core_req_addr  in  ADDR_WIDTH  request address
- core_req_data  in  DATA_WIDTH  write data
- core_req_tag  in  TAG_WIDTH  request tag
- core_req_ready  out  1  request accepted
- core_rsp_valid  out  1  response valid to Vortex
- core_rsp_data  out  DATA_WIDTH  read data
- core_rsp_tag  out  TAG_WIDTH  response tag
- core_rsp_ready  in  1  Vortex accepts response
- mem_req_valid  out  1  request valid to memory
- mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag  out  same widths as the core_req_* inputs  forwarded request fields
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  DATA_WIDTH  memory read data
- mem_rsp_tag  in  TAG_WIDTH  memory response tag
- mem_rsp_ready  out  1  ready for memory response
- busy  out  1  reads outstanding or responses buffered
- overflow_err  out  1  sticky protocol-error flag

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high. While reset is high: credits = 0, FIFO empty, core_rsp_valid = 0, mem_rsp_ready = 0, overflow_err = 0, busy = 0.
  - mem_rsp_ready is registered: it goes to 1 on the first clock edge after reset deasserts and stays 1.
- Request path:
  - Combinational, zero latency. mem_req_* fields equal core_req_*.
  - can_issue = core_req_rw | (credits != DEPTH).
  - mem_req_valid = core_req_valid & can_issue.
  - core_req_ready = mem_req_ready & can_issue.
  - Request fire = core_req_valid & core_req_ready.
- Writes:
  - Consume no credit and produce no response.
  - Writes still pass while credits == DEPTH.
- Credit counter:
  - Width clog2(DEPTH)+1; counts outstanding reads plus FIFO occupancy.
  - +1 on a read fire; -1 on core response fire (core_rsp_valid & core_rsp_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds DEPTH and never goes below 0.
- Response FIFO:
  - DEPTH entries of {tag, data}, strictly in memory-arrival order.
  - Written when mem_rsp_valid & mem_rsp_ready.
  - An entry becomes visible at core_rsp_* one cycle after the write; no combinational bypass from mem_rsp to core_rsp.
  - core_rsp_valid = FIFO not empty; core_rsp_data and core_rsp_tag come from the head entry and are held stable while valid & !ready.
  - Push and pop in the same cycle on a non-empty FIFO: occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Overflow:
  - mem_rsp_valid arriving while the FIFO is full: data dropped, overflow_err set to 1 and held until reset.
  - This is a downstream protocol violation and cannot occur under credit control.
- busy = (credits != 0), registered view of the counter.
- Reset asserted mid-operation: in-flight reads are discarded, credits return to 0, and the FIFO is flushed immediately (asynchronously).

Test Plan:
- Single read (addr 0x100, tag 0x05), mem_req_ready = 1, memory responds 3 cycles later with data 0xAA..AA -> core_rsp_valid rises exactly 1 cycle after mem_rsp_valid with tag 0x05; busy is 1 from the cycle after the request until the cycle after the response pop.
- DEPTH = 8, eight reads issued, core_rsp_ready = 0 -> 9th read sees core_req_ready = 0 and mem_req_valid = 0; a write (rw = 1) issued in the same state passes with core_req_ready = 1; one pop re-enables reads the next cycle.
- Response push and core pop in the same cycle with occupancy 3 -> occupancy stays 3, credits unchanged, head order preserved (tags 1, 2, 3, 4 exit in that order).
- core_rsp_ready = 0 for 5 cycles with a valid head -> core_rsp_data and core_rsp_tag stable across all 5 cycles.
- Force a 9th memory response with the FIFO full (misbehaving memory model) -> overflow_err = 1 and remains set; FIFO contents unchanged.
- Assert reset with 4 outstanding reads and 2 buffered responses -> core_rsp_valid = 0, busy = 0 and mem_rsp_ready = 0 immediately; after release, mem_rsp_ready = 1 one cycle later and credits = 0.
